// File: rtl/vga_frame_sequencer_pkg.sv
// vga_pkg: phase encoding, 640x480@60 timing defaults and the 8-colour palette.
package vga_pkg;
    typedef enum logic [1:0] {SYNC = 2'd0, BACK = 2'd1, ACTIVE = 2'd2, FRONT = 2'd3} phase_t;
    localparam int CW = 10;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BACK_DEF = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF = 16;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BACK_DEF = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF = 10;
    localparam int FRAMES_PER_COLOR_DEF = 60;
    function automatic logic [11:0] palette(input logic [2:0] i);
        return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
    endfunction
endpackage

// File: rtl/vga_frame_sequencer_if.sv
// vga_frame_sequencer_if: VGA pins, pattern select and pixel-stage qualifiers.
interface vga_frame_sequencer_if;
    logic [1:0] MODE;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       pix_en;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       active;
    logic       frame_start;
    modport master (input MODE, output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, pix_en, pix_x, pix_y, active, frame_start);
    modport slave (output MODE, input VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, pix_en, pix_x, pix_y, active, frame_start);
endinterface

// File: rtl/vga_frame_sequencer_axis_counter.sv
// vga_axis_counter: one timing axis; count and SYNC/BACK/ACTIVE/FRONT phase registered together.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC_LEN   = H_SYNC_DEF,
    parameter int BACK_LEN   = H_BACK_DEF,
    parameter int ACTIVE_LEN = H_ACTIVE_DEF,
    parameter int FRONT_LEN  = H_FRONT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          advance,
    output logic [CW-1:0] count,
    output phase_t        phase,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST      = CW'(SYNC_LEN + BACK_LEN + ACTIVE_LEN + FRONT_LEN - 1);
    localparam logic [CW-1:0] BACK_AT   = CW'(SYNC_LEN);
    localparam logic [CW-1:0] ACTIVE_AT = CW'(SYNC_LEN + BACK_LEN);
    localparam logic [CW-1:0] FRONT_AT  = CW'(SYNC_LEN + BACK_LEN + ACTIVE_LEN);
    logic [CW-1:0] count_n;
    phase_t        phase_n;
    assign wrap = count == LAST;
    // phase changes on entering a boundary count, so it never needs decoding from count
    always_comb begin
        count_n = wrap ? '0 : count + 1'b1;
        phase_n = count_n == '0 ? SYNC :
                  count_n == BACK_AT ? BACK :
                  count_n == ACTIVE_AT ? ACTIVE :
                  count_n == FRONT_AT ? FRONT : phase;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count <= '0;
            phase <= SYNC;
        end else if (tick && advance) begin
            count <= count_n;
            phase <= phase_n;
        end
endmodule

// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer: 640x480@60 VGA timing plus frame-scheduled test-pattern colour source.
module vga_frame_sequencer
    import vga_pkg::*;
#(
    parameter int H_SYNC           = H_SYNC_DEF,
    parameter int H_BACK           = H_BACK_DEF,
    parameter int H_ACTIVE         = H_ACTIVE_DEF,
    parameter int H_FRONT          = H_FRONT_DEF,
    parameter int V_SYNC           = V_SYNC_DEF,
    parameter int V_BACK           = V_BACK_DEF,
    parameter int V_ACTIVE         = V_ACTIVE_DEF,
    parameter int V_FRONT          = V_FRONT_DEF,
    parameter int FRAMES_PER_COLOR = FRAMES_PER_COLOR_DEF
) (
    input logic                    CLOCK_50,
    input logic                    RESET_N,
    vga_frame_sequencer_if.master  vga
);
    localparam int FW = $clog2(FRAMES_PER_COLOR + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_COLOR - 1);
    localparam logic [CW-1:0] X0 = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] Y0 = CW'(V_SYNC + V_BACK);
    logic          pix_en, frame_start, h_wrap, v_wrap, active, hs_q, vs_q;
    logic [CW-1:0] h_cnt, v_cnt, pix_x, pix_y;
    phase_t        h_phase, v_phase;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    colour_idx, pat_idx;
    logic [1:0]    mode_q;
    logic [11:0]   rgb_n, rgb_q;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) pix_en <= 1'b0;
        else pix_en <= ~pix_en;
    vga_axis_counter #(.SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK), .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT)) u_h (
        .clk(CLOCK_50), .rst_n(RESET_N), .tick(pix_en), .advance(1'b1),
        .count(h_cnt), .phase(h_phase), .wrap(h_wrap)
    );
    vga_axis_counter #(.SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK), .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT)) u_v (
        .clk(CLOCK_50), .rst_n(RESET_N), .tick(pix_en), .advance(h_wrap),
        .count(v_cnt), .phase(v_phase), .wrap(v_wrap)
    );
    always_comb begin
        pix_x   = h_phase == ACTIVE ? h_cnt - X0 : '0;
        pix_y   = v_phase == ACTIVE ? v_cnt - Y0 : '0;
        active  = h_phase == ACTIVE && v_phase == ACTIVE;
        pat_idx = mode_q == 2'd1 ? colour_idx + pix_x[9:7] :
                  mode_q == 2'd2 ? colour_idx + pix_y[8:6] : colour_idx;
        rgb_n   = !active || (mode_q == 2'd3 && (pix_x[6] ^ pix_y[6])) ? '0 : palette(pat_idx);
    end
    // pattern settings are sampled only at the frame origin so a frame is never mixed
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            colour_idx  <= '0;
            mode_q      <= '0;
        end else begin
            frame_start <= pix_en && h_wrap && v_wrap;
            if (frame_start) begin
                mode_q     <= vga.MODE;
                frame_cnt  <= frame_cnt == FRAME_LAST ? '0 : frame_cnt + 1'b1;
                colour_idx <= frame_cnt == FRAME_LAST ? colour_idx + 1'b1 : colour_idx;
            end
        end
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else if (pix_en) begin
            hs_q  <= h_phase != SYNC;
            vs_q  <= v_phase != SYNC;
            rgb_q <= rgb_n;
        end
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_R       = rgb_q[11:8];
    assign vga.VGA_G       = rgb_q[7:4];
    assign vga.VGA_B       = rgb_q[3:0];
    assign vga.pix_en      = pix_en;
    assign vga.pix_x       = pix_x;
    assign vga.pix_y       = pix_y;
    assign vga.active      = active;
    assign vga.frame_start = frame_start;
endmodule
